// File: rtl/scsi_reg_cycle_pkg.sv
// Shared SDMAC definitions for the WD33C93 register-cycle sequencer:
// FSM state encoding, default cycle timings and timer width.
package scsi_reg_cycle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_TERM    = 3'd4,
        ST_WAIT_AS = 3'd5
    } state_t;

    localparam int T_SETUP_DEF  = 1;
    localparam int T_STROBE_DEF = 3;
    localparam int T_HOLD_DEF   = 1;
    localparam int T_REC_DEF    = 2;
    localparam int TMR_W        = 3;

    // Clamp a timing value into the 3-bit counter range.
    function automatic logic [TMR_W-1:0] sat3(input int v);
        if (v < 0) return '0;
        if (v > 7) return 3'd7;
        return 3'(v);
    endfunction

endpackage

// File: rtl/scsi_reg_cycle_if.sv
// CPU-side decode inputs and WD33C93-side bus signals of the register-cycle sequencer.
interface scsi_reg_cycle_if;
    logic       as_n;
    logic       ds_n;
    logic       r_w;
    logic       dmac_n;
    logic [4:0] addr;
    logic [7:0] pd;
    logic       wdregreq;
    logic       css_n;
    logic       ior_n;
    logic       iow_n;
    logic       wd_a0;
    logic [7:0] rd_data;
    logic       wd_dsk_n;

    modport master (
        output as_n, ds_n, r_w, dmac_n, addr, pd,
        input  wdregreq, css_n, ior_n, iow_n, wd_a0, rd_data, wd_dsk_n
    );

    modport slave (
        input  as_n, ds_n, r_w, dmac_n, addr, pd,
        output wdregreq, css_n, ior_n, iow_n, wd_a0, rd_data, wd_dsk_n
    );
endinterface

// File: rtl/sdmac_timer.sv
// 3-bit loadable down-counter that stops at zero; used for phase and recovery timing.
module sdmac_timer
    import scsi_reg_cycle_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);
    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 3'd1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/scsi_reg_cycle.sv
// WD33C93 register-cycle sequencer: decodes CPU accesses, times CSS_/IOR_/IOW_,
// captures read data and terminates the cycle toward the DSACK merge.
//   state   | meaning
//   IDLE    | bus free; start once recovery has expired
//   SETUP   | CSS_ low, strobes high
//   STROBE  | IOR_ or IOW_ low
//   HOLD    | strobes high, CSS_ still low
//   TERM    | WD_DSK_ low until AS_ rises
//   WAIT_AS | after reset, ignore the access in flight until AS_ goes high
module scsi_reg_cycle
    import scsi_reg_cycle_pkg::*;
#(
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_STROBE = T_STROBE_DEF,
    parameter int T_HOLD   = T_HOLD_DEF,
    parameter int T_REC    = T_REC_DEF
) (
    input logic             clk,
    input logic             rst_n,
    scsi_reg_cycle_if.slave bus
);
    // Phase timer loads T-1 so a state lasts exactly T clocks.
    localparam logic [TMR_W-1:0] LD_SETUP  = sat3(T_SETUP - 1);
    localparam logic [TMR_W-1:0] LD_STROBE = sat3(T_STROBE - 1);
    localparam logic [TMR_W-1:0] LD_HOLD   = sat3(T_HOLD - 1);
    localparam logic [TMR_W-1:0] LD_REC    = sat3(T_REC);

    state_t           state;
    state_t           nxt;
    logic             phase_load;
    logic [TMR_W-1:0] phase_val;
    logic             phase_zero;
    logic             rec_load;
    logic             rec_zero;
    logic             qual;
    logic             start;
    logic             rw_q;
    logic             abort_q;
    logic             armed;
    logic             wait_req;
    logic             unused_addr;

    assign unused_addr = ^{bus.addr[3:2], bus.addr[0]};

    assign qual  = !bus.as_n && !bus.ds_n && !bus.dmac_n && bus.addr[4];
    assign start = qual && armed && rec_zero;

    sdmac_timer u_phase (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (phase_load),
        .load_val (phase_val),
        .zero     (phase_zero)
    );

    sdmac_timer u_rec (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rec_load),
        .load_val (LD_REC),
        .zero     (rec_zero)
    );

    always_comb begin
        nxt        = state;
        phase_load = 1'b0;
        phase_val  = '0;
        rec_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    nxt        = ST_SETUP;
                    phase_load = 1'b1;
                    phase_val  = LD_SETUP;
                end else if (!armed && !bus.as_n) begin
                    nxt = ST_WAIT_AS;
                end
            end
            ST_SETUP: begin
                if (bus.as_n) begin
                    nxt      = ST_IDLE;
                    rec_load = 1'b1;
                end else if (phase_zero) begin
                    nxt        = ST_STROBE;
                    phase_load = 1'b1;
                    phase_val  = LD_STROBE;
                end
            end
            ST_STROBE: begin
                if (phase_zero) begin
                    nxt        = ST_HOLD;
                    phase_load = 1'b1;
                    phase_val  = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (phase_zero) begin
                    if (abort_q || bus.as_n) begin
                        nxt      = ST_IDLE;
                        rec_load = 1'b1;
                    end else begin
                        nxt = ST_TERM;
                    end
                end
            end
            ST_TERM: begin
                if (bus.as_n) begin
                    nxt      = ST_IDLE;
                    rec_load = 1'b1;
                end
            end
            ST_WAIT_AS: begin
                if (bus.as_n) nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // A qualified access held off by recovery still claims the bus.
    assign wait_req = (state == ST_IDLE) && (nxt == ST_IDLE) && qual && armed && !rec_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rw_q         <= 1'b0;
            abort_q      <= 1'b0;
            armed        <= 1'b0;
            bus.css_n    <= 1'b1;
            bus.ior_n    <= 1'b1;
            bus.iow_n    <= 1'b1;
            bus.wd_dsk_n <= 1'b1;
            bus.wdregreq <= 1'b0;
            bus.wd_a0    <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            state <= nxt;
            if (bus.as_n) armed <= 1'b1;
            if (state == ST_IDLE && start) begin
                rw_q      <= bus.r_w;
                bus.wd_a0 <= bus.addr[1];
                abort_q   <= 1'b0;
            end else if (state == ST_STROBE && bus.as_n) begin
                abort_q <= 1'b1;
            end
            if (state == ST_STROBE && phase_zero && rw_q) bus.rd_data <= bus.pd;
            bus.css_n    <= !(nxt == ST_SETUP || nxt == ST_STROBE || nxt == ST_HOLD);
            bus.ior_n    <= !(nxt == ST_STROBE && rw_q);
            bus.iow_n    <= !(nxt == ST_STROBE && !rw_q);
            bus.wd_dsk_n <= !(nxt == ST_TERM);
            bus.wdregreq <= (nxt == ST_SETUP || nxt == ST_STROBE || nxt == ST_HOLD ||
                             nxt == ST_TERM || wait_req);
        end
    end
endmodule

// File: tb/tb_scsi_reg_cycle.sv
// Self-checking bench for scsi_reg_cycle: per-cycle expectations are queued
// before each access is driven and compared once the access has completed.
module tb_scsi_reg_cycle;
    import scsi_reg_cycle_pkg::*;

    localparam int TS   = 1;
    localparam int TSTB = 3;
    localparam int TH   = 1;
    localparam int TR   = 2;
    localparam int D    = TS + TSTB + TH + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    scsi_reg_cycle_if bus ();

    scsi_reg_cycle dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         css_first;
        int         css_clks;
        int         ior_clks;
        int         iow_clks;
        int         strobe_first;
        int         dsk_first;
        int         dsk_clks;
        int         req_clks;
        int         viol;
        logic       a0;
        logic [7:0] rd;
    } obs_t;

    obs_t exp_q[$];

    task automatic idle(input int n);
        @(negedge clk);
        bus.as_n   = 1'b1;
        bus.ds_n   = 1'b1;
        bus.dmac_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // rel = 0 releases AS_ when WD_DSK_ is seen low; otherwise on clock rel.
    task automatic run_cycle(input logic [4:0] a, input logic rw, input logic [7:0] pd,
                             input int rel, input int win, output obs_t o);
        o = '{default: 0};
        @(negedge clk);
        bus.addr   = a;
        bus.r_w    = rw;
        bus.pd     = pd;
        bus.as_n   = 1'b0;
        bus.ds_n   = 1'b0;
        bus.dmac_n = 1'b0;
        for (int k = 1; k <= win; k++) begin
            @(negedge clk);
            if (!bus.css_n) begin
                o.css_clks += 1;
                if (o.css_first == 0) begin
                    o.css_first = k;
                    o.a0 = bus.wd_a0;
                end
            end
            if (!bus.ior_n) o.ior_clks += 1;
            if (!bus.iow_n) o.iow_clks += 1;
            if ((!bus.ior_n || !bus.iow_n) && o.strobe_first == 0) o.strobe_first = k;
            if (!bus.wd_dsk_n) begin
                o.dsk_clks += 1;
                if (o.dsk_first == 0) begin
                    o.dsk_first = k;
                    o.rd = bus.rd_data;
                end
            end
            if (bus.wdregreq) o.req_clks += 1;
            if ((!bus.ior_n && !bus.iow_n) || ((!bus.ior_n || !bus.iow_n) && bus.css_n))
                o.viol += 1;
            if ((rel == 0 && !bus.wd_dsk_n) || k == rel) begin
                bus.as_n = 1'b1;
                bus.ds_n = 1'b1;
            end
        end
        if (o.css_first == 0) o.a0 = bus.wd_a0;
        if (o.dsk_first == 0) o.rd = bus.rd_data;
        bus.as_n   = 1'b1;
        bus.ds_n   = 1'b1;
        bus.dmac_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.as_n = 1'b1; bus.ds_n = 1'b1; bus.dmac_n = 1'b1;
        bus.r_w = 1'b0; bus.addr = '0; bus.pd = '0;
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.css_n, bus.ior_n, bus.iow_n, bus.wd_dsk_n} !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 1111", {bus.css_n, bus.ior_n, bus.iow_n, bus.wd_dsk_n});
        end
        n_tests++;
        if ({bus.wdregreq, bus.wd_a0, bus.rd_data} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_regs: got req=%b a0=%b rd=%h want 0 0 00", bus.wdregreq, bus.wd_a0, bus.rd_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_write();
        obs_t o, e;
        e = '{default: 0};
        e.css_first = 1; e.css_clks = TS + TSTB + TH; e.strobe_first = TS + 1;
        e.iow_clks = TSTB; e.dsk_first = D; e.dsk_clks = 1; e.req_clks = D; e.a0 = 1'b1; e.rd = 8'h00;
        exp_q.push_back(e);
        idle(4);
        run_cycle(5'h12, 1'b0, 8'h5A, 0, 12, o);
        e = exp_q.pop_front();
        n_tests++; if (o.css_first !== e.css_first) begin n_fail++; $display("FAIL write_css_first: got %0d want %0d", o.css_first, e.css_first); end
        n_tests++; if (o.css_clks !== e.css_clks) begin n_fail++; $display("FAIL write_css_clks: got %0d want %0d", o.css_clks, e.css_clks); end
        n_tests++; if (o.strobe_first !== e.strobe_first) begin n_fail++; $display("FAIL write_iow_first: got %0d want %0d", o.strobe_first, e.strobe_first); end
        n_tests++; if (o.iow_clks !== e.iow_clks || o.ior_clks !== 0) begin n_fail++; $display("FAIL write_iow_clks: got iow=%0d ior=%0d want %0d 0", o.iow_clks, o.ior_clks, e.iow_clks); end
        n_tests++; if (o.dsk_first !== e.dsk_first || o.dsk_clks !== e.dsk_clks) begin n_fail++; $display("FAIL write_dsk: got first=%0d n=%0d want %0d %0d", o.dsk_first, o.dsk_clks, e.dsk_first, e.dsk_clks); end
        n_tests++; if (o.req_clks !== e.req_clks) begin n_fail++; $display("FAIL write_wdregreq: got %0d want %0d", o.req_clks, e.req_clks); end
        n_tests++; if (o.a0 !== e.a0) begin n_fail++; $display("FAIL write_a0: got %b want %b", o.a0, e.a0); end
        n_tests++; if (o.rd !== e.rd || o.viol !== 0) begin n_fail++; $display("FAIL write_rd_viol: got rd=%h viol=%0d want %h 0", o.rd, o.viol, e.rd); end
    endtask

    task automatic test_read();
        obs_t o, e;
        e = '{default: 0};
        e.css_clks = TS + TSTB + TH; e.strobe_first = TS + 1; e.ior_clks = TSTB;
        e.dsk_first = D; e.a0 = 1'b0; e.rd = 8'hA5;
        exp_q.push_back(e);
        idle(4);
        run_cycle(5'h10, 1'b1, 8'hA5, 0, 12, o);
        e = exp_q.pop_front();
        n_tests++; if (o.ior_clks !== e.ior_clks || o.iow_clks !== 0) begin n_fail++; $display("FAIL read_ior_clks: got ior=%0d iow=%0d want %0d 0", o.ior_clks, o.iow_clks, e.ior_clks); end
        n_tests++; if (o.strobe_first !== e.strobe_first) begin n_fail++; $display("FAIL read_ior_first: got %0d want %0d", o.strobe_first, e.strobe_first); end
        n_tests++; if (o.rd !== e.rd) begin n_fail++; $display("FAIL read_rd_data: got %h want %h", o.rd, e.rd); end
        n_tests++; if (o.a0 !== e.a0) begin n_fail++; $display("FAIL read_a0: got %b want %b", o.a0, e.a0); end
        n_tests++; if (o.dsk_first !== e.dsk_first || o.css_clks !== e.css_clks) begin n_fail++; $display("FAIL read_term: got dsk=%0d css=%0d want %0d %0d", o.dsk_first, o.css_clks, e.dsk_first, e.css_clks); end
    endtask

    task automatic test_back_to_back();
        int fall1, fall2, dsk_cnt, relk;
        logic prev_css, reissued;
        logic [7:0] rd_q[$];
        logic [7:0] rd_exp;
        fall1 = 0; fall2 = 0; dsk_cnt = 0; relk = 0; prev_css = 1'b1; reissued = 1'b0;
        idle(4);
        bus.addr = 5'h10; bus.r_w = 1'b1; bus.pd = 8'h11; rd_q.push_back(8'h11);
        bus.as_n = 1'b0; bus.ds_n = 1'b0; bus.dmac_n = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (!bus.css_n && prev_css) begin
                if (fall1 == 0) fall1 = k;
                else if (fall2 == 0) fall2 = k;
            end
            prev_css = bus.css_n;
            if (reissued && k == relk + 2) begin
                n_tests++;
                if (bus.wdregreq !== 1'b1 || bus.css_n !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_recovery_wait: got req=%b css_n=%b want 1 1", bus.wdregreq, bus.css_n);
                end
            end
            if (!bus.wd_dsk_n && !bus.as_n) begin
                dsk_cnt++;
                rd_exp = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hxx;
                n_tests++;
                if (bus.rd_data !== rd_exp) begin
                    n_fail++;
                    $display("FAIL b2b_rd_data%0d: got %h want %h", dsk_cnt, bus.rd_data, rd_exp);
                end
                bus.as_n = 1'b1; bus.ds_n = 1'b1;
                if (dsk_cnt == 1) relk = k;
            end else if (dsk_cnt == 1 && !reissued && k == relk + 1) begin
                bus.pd = 8'h22; rd_q.push_back(8'h22);
                bus.as_n = 1'b0; bus.ds_n = 1'b0;
                reissued = 1'b1;
            end
        end
        n_tests++; if (fall1 !== 1 || relk !== D) begin n_fail++; $display("FAIL b2b_first: got css=%0d term=%0d want 1 %0d", fall1, relk, D); end
        n_tests++; if (fall2 < relk + 1 + TR || fall2 > relk + 2 + TR) begin n_fail++; $display("FAIL b2b_second_css: got clock %0d want %0d..%0d", fall2, relk + 1 + TR, relk + 2 + TR); end
        n_tests++; if (dsk_cnt !== 2 || rd_q.size() !== 0) begin n_fail++; $display("FAIL b2b_count: got %0d terms %0d pending want 2 0", dsk_cnt, rd_q.size()); end
        idle(2);
    endtask

    task automatic test_abort_strobe();
        obs_t o, e;
        e = '{default: 0};
        e.css_clks = TS + TSTB + TH; e.ior_clks = TSTB; e.req_clks = TS + TSTB + TH; e.rd = 8'h3C;
        exp_q.push_back(e);
        idle(4);
        run_cycle(5'h10, 1'b1, 8'h3C, TS + 1, 12, o);
        e = exp_q.pop_front();
        n_tests++; if (o.ior_clks !== e.ior_clks) begin n_fail++; $display("FAIL abort_strobe_ior: got %0d want %0d", o.ior_clks, e.ior_clks); end
        n_tests++; if (o.dsk_clks !== 0) begin n_fail++; $display("FAIL abort_strobe_dsk: got %0d clocks low want 0", o.dsk_clks); end
        n_tests++; if (o.css_clks !== e.css_clks || o.req_clks !== e.req_clks) begin n_fail++; $display("FAIL abort_strobe_css: got css=%0d req=%0d want %0d %0d", o.css_clks, o.req_clks, e.css_clks, e.req_clks); end
        n_tests++; if (o.rd !== e.rd || o.viol !== 0) begin n_fail++; $display("FAIL abort_strobe_rd: got rd=%h viol=%0d want %h 0", o.rd, o.viol, e.rd); end
    endtask

    task automatic test_abort_setup();
        obs_t o, e;
        e = '{default: 0};
        e.css_clks = 1; e.req_clks = 1; e.rd = 8'h3C;
        exp_q.push_back(e);
        idle(4);
        run_cycle(5'h10, 1'b1, 8'h77, 1, 10, o);
        e = exp_q.pop_front();
        n_tests++; if (o.css_clks !== e.css_clks || o.req_clks !== e.req_clks) begin n_fail++; $display("FAIL abort_setup_css: got css=%0d req=%0d want %0d %0d", o.css_clks, o.req_clks, e.css_clks, e.req_clks); end
        n_tests++; if (o.ior_clks !== 0 || o.dsk_clks !== 0) begin n_fail++; $display("FAIL abort_setup_strobe: got ior=%0d dsk=%0d want 0 0", o.ior_clks, o.dsk_clks); end
        n_tests++; if (o.rd !== e.rd) begin n_fail++; $display("FAIL abort_setup_rd: got %h want %h", o.rd, e.rd); end
    endtask

    task automatic test_ignored();
        obs_t o, e;
        e = '{default: 0};
        exp_q.push_back(e);
        idle(4);
        run_cycle(5'h03, 1'b0, 8'h00, 4, 8, o);
        e = exp_q.pop_front();
        n_tests++; if (o.css_clks !== e.css_clks || o.req_clks !== e.req_clks) begin n_fail++; $display("FAIL ignored_css_req: got css=%0d req=%0d want 0 0", o.css_clks, o.req_clks); end
        n_tests++; if (o.dsk_clks !== e.dsk_clks || o.iow_clks !== e.iow_clks) begin n_fail++; $display("FAIL ignored_dsk_iow: got dsk=%0d iow=%0d want 0 0", o.dsk_clks, o.iow_clks); end
    endtask

    task automatic test_reset_mid();
        int css_cnt, req_cnt, first;
        logic dsk_seen;
        css_cnt = 0; req_cnt = 0; first = 0; dsk_seen = 1'b0;
        idle(4);
        bus.addr = 5'h10; bus.r_w = 1'b1; bus.pd = 8'h99;
        bus.as_n = 1'b0; bus.ds_n = 1'b0; bus.dmac_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (bus.ior_n !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_strobe: got ior_n=%b want 0", bus.ior_n); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.css_n, bus.ior_n, bus.iow_n, bus.wd_dsk_n, bus.wdregreq} !== 5'b11110) begin
            n_fail++;
            $display("FAIL rst_mid_idle: got %b want 11110", {bus.css_n, bus.ior_n, bus.iow_n, bus.wd_dsk_n, bus.wdregreq});
        end
        n_tests++; if (bus.rd_data !== 8'h00 || bus.wd_a0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_regs: got rd=%h a0=%b want 00 0", bus.rd_data, bus.wd_a0); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!bus.css_n) css_cnt++;
            if (bus.wdregreq) req_cnt++;
        end
        n_tests++; if (css_cnt !== 0 || req_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_no_restart: got css=%0d req=%0d want 0 0", css_cnt, req_cnt); end
        bus.as_n = 1'b1; bus.ds_n = 1'b1;
        @(negedge clk);
        bus.as_n = 1'b0; bus.ds_n = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!bus.css_n && first == 0) first = k;
            if (!bus.wd_dsk_n) begin
                dsk_seen = 1'b1;
                bus.as_n = 1'b1; bus.ds_n = 1'b1;
            end
        end
        n_tests++; if (first !== 1 || dsk_seen !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rearm: got css_first=%0d dsk=%b want 1 1", first, dsk_seen); end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_abort_strobe();
        test_abort_setup();
        test_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no end want end");
        $fatal(1);
    end
endmodule
